// File: rtl/wakeup_scoreboard.sv
// Wakeup scoreboard: registers a gated broadcast tag per writeback channel and keeps a
// physical-register ready table with allocation clears, wakeup sets and same-cycle query bypass.
module wakeup_scoreboard #(
  parameter int NUM_WB    = 4,
  parameter int PR_W      = 6,
  parameter int NUM_PR    = 64,
  parameter int NUM_ALLOC = 2,
  parameter int NUM_QUERY = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_WB-1:0]         wb_vld,
  input  logic [NUM_WB*PR_W-1:0]    wb_pr,
  output logic [NUM_WB*PR_W-1:0]    wb_dest,
  input  logic [NUM_ALLOC-1:0]      alloc_vld,
  input  logic [NUM_ALLOC*PR_W-1:0] alloc_pr,
  input  logic [NUM_QUERY*PR_W-1:0] query_pr,
  output logic [NUM_QUERY-1:0]      query_rdy,
  output logic [PR_W:0]             busy_cnt
);

  logic [NUM_PR-1:0]      ready_q, ready_d;
  logic [PR_W:0]          busy_q, busy_d;
  logic [NUM_WB*PR_W-1:0] wb_dest_q, wb_dest_d;
  logic [NUM_PR-1:0]      wake_vec  [NUM_WB];
  logic [NUM_PR-1:0]      alloc_vec [NUM_ALLOC];

  for (genvar i = 0; i < NUM_WB; i++) begin : g_wb
    logic [PR_W-1:0] pr;
    logic            hit;
    assign pr          = wb_pr[i*PR_W +: PR_W];
    assign hit         = wb_vld[i] && (pr != '0);
    assign wake_vec[i] = hit ? (NUM_PR'(1) << pr) : '0;
    assign wb_dest_d[i*PR_W +: PR_W] = (hit && !flush) ? pr : '0;
  end

  for (genvar j = 0; j < NUM_ALLOC; j++) begin : g_alloc
    logic [PR_W-1:0] pr;
    assign pr           = alloc_pr[j*PR_W +: PR_W];
    assign alloc_vec[j] = (alloc_vld[j] && (pr != '0)) ? (NUM_PR'(1) << pr) : '0;
  end

  // Bypass compares raw wakeup tags and ignores flush; a null query tag is ready regardless.
  for (genvar k = 0; k < NUM_QUERY; k++) begin : g_query
    logic [PR_W-1:0] q;
    logic            byp;
    assign q = query_pr[k*PR_W +: PR_W];
    always_comb begin
      byp = 1'b0;
      for (int i = 0; i < NUM_WB; i++) begin
        if (wb_vld[i] && (wb_pr[i*PR_W +: PR_W] == q)) byp = 1'b1;
      end
    end
    assign query_rdy[k] = (q == '0) || ready_q[q] || byp;
  end

  always_comb begin
    logic [NUM_PR-1:0] wake_all, alloc_all;
    wake_all  = '0;
    alloc_all = '0;
    for (int i = 0; i < NUM_WB; i++)    wake_all  = wake_all  | wake_vec[i];
    for (int j = 0; j < NUM_ALLOC; j++) alloc_all = alloc_all | alloc_vec[j];
    // Clearing after setting lets an allocation win over a same-cycle wakeup.
    ready_d = (ready_q | wake_all) & ~alloc_all;
    if (flush) ready_d = '1;
    ready_d[0] = 1'b1;
    busy_d = '0;
    for (int p = 0; p < NUM_PR; p++) busy_d = busy_d + {{PR_W{1'b0}}, ~ready_d[p]};
  end

  // NOTE: the ready table is ordinary flops, not a RAM, so it is reset along with the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q   <= '1;
      busy_q    <= '0;
      wb_dest_q <= '0;
    end else begin
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      wb_dest_q <= wb_dest_d;
    end
  end

  assign wb_dest  = wb_dest_q;
  assign busy_cnt = busy_q;

endmodule

// File: tb/tb_wakeup_scoreboard.sv
// Directed self-checking bench for wakeup_scoreboard: reset, alloc/wake, conflicts,
// null tag and duplicates, flush, and asynchronous reset mid-stream.
module tb_wakeup_scoreboard;
  localparam int NUM_WB = 4, PR_W = 6, NUM_PR = 64, NUM_ALLOC = 2, NUM_QUERY = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic [NUM_WB-1:0]         wb_vld;
  logic [NUM_WB*PR_W-1:0]    wb_pr;
  logic [NUM_WB*PR_W-1:0]    wb_dest;
  logic [NUM_ALLOC-1:0]      alloc_vld;
  logic [NUM_ALLOC*PR_W-1:0] alloc_pr;
  logic [NUM_QUERY*PR_W-1:0] query_pr;
  logic [NUM_QUERY-1:0]      query_rdy;
  logic [PR_W:0]             busy_cnt;

  logic [PR_W-1:0] wp [NUM_WB];
  logic [PR_W-1:0] ap [NUM_ALLOC];
  logic [PR_W-1:0] qp [NUM_QUERY];
  logic [PR_W-1:0] wd [NUM_WB];

  int n_chk = 0;
  int n_fail = 0;

  wakeup_scoreboard #(.NUM_WB(NUM_WB), .PR_W(PR_W), .NUM_PR(NUM_PR),
                      .NUM_ALLOC(NUM_ALLOC), .NUM_QUERY(NUM_QUERY)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wb_vld(wb_vld), .wb_pr(wb_pr),
    .wb_dest(wb_dest), .alloc_vld(alloc_vld), .alloc_pr(alloc_pr),
    .query_pr(query_pr), .query_rdy(query_rdy), .busy_cnt(busy_cnt));

  always #5 clk = ~clk;

  assign wb_pr    = {wp[3], wp[2], wp[1], wp[0]};
  assign alloc_pr = {ap[1], ap[0]};
  assign query_pr = {qp[3], qp[2], qp[1], qp[0]};
  for (genvar i = 0; i < NUM_WB; i++) begin : g_unpack
    assign wd[i] = wb_dest[i*PR_W +: PR_W];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    flush = 1'b0; wb_vld = '0; alloc_vld = '0;
    for (int i = 0; i < NUM_WB; i++) wp[i] = '0;
    for (int j = 0; j < NUM_ALLOC; j++) ap[j] = '0;
    for (int k = 0; k < NUM_QUERY; k++) qp[k] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      flush = 1'($urandom); wb_vld = 4'($urandom); alloc_vld = 2'($urandom);
      for (int i = 0; i < NUM_WB; i++) wp[i] = 6'($urandom);
      for (int j = 0; j < NUM_ALLOC; j++) ap[j] = 6'($urandom);
      for (int k = 0; k < NUM_QUERY; k++) qp[k] = 6'($urandom);
      tick();
      n_chk++; if (wb_dest !== '0) begin n_fail++; $display("FAIL reset_wb_dest: got %h exp 0", wb_dest); end
      n_chk++; if (busy_cnt !== 7'd0) begin n_fail++; $display("FAIL reset_busy: got %0d exp 0", busy_cnt); end
      n_chk++; if (query_rdy !== 4'hF) begin n_fail++; $display("FAIL reset_query: got %b exp 1111", query_rdy); end
    end
    clr();
    tick();
    rst = 1'b0;
    tick();
    n_chk++; if (busy_cnt !== 7'd0) begin n_fail++; $display("FAIL reset_release_busy: got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_alloc_wake();
    alloc_vld = 2'b01; ap[0] = 6'd5;
    tick();
    clr(); qp[0] = 6'd5; #1;
    n_chk++; if (query_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL alloc_query5: got %b exp 0", query_rdy[0]); end
    n_chk++; if (busy_cnt !== 7'd1) begin n_fail++; $display("FAIL alloc_busy: got %0d exp 1", busy_cnt); end
    tick(); tick();
    n_chk++; if (query_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL alloc_hold_query5: got %b exp 0", query_rdy[0]); end
    wb_vld = 4'b0100; wp[2] = 6'd5; #1;
    n_chk++; if (query_rdy[0] !== 1'b1) begin n_fail++; $display("FAIL wake_bypass: got %b exp 1", query_rdy[0]); end
    tick();
    clr(); qp[0] = 6'd5; #1;
    n_chk++; if (wd[2] !== 6'd5) begin n_fail++; $display("FAIL wake_wb_dest2: got %0d exp 5", wd[2]); end
    n_chk++; if (wd[0] !== 6'd0 || wd[1] !== 6'd0 || wd[3] !== 6'd0) begin n_fail++; $display("FAIL wake_other_dest: got %h exp only ch2", wb_dest); end
    n_chk++; if (busy_cnt !== 7'd0) begin n_fail++; $display("FAIL wake_busy: got %0d exp 0", busy_cnt); end
    n_chk++; if (query_rdy[0] !== 1'b1) begin n_fail++; $display("FAIL wake_table5: got %b exp 1", query_rdy[0]); end
    tick();
    n_chk++; if (wb_dest !== '0) begin n_fail++; $display("FAIL wake_dest_clear: got %h exp 0", wb_dest); end
  endtask

  task automatic test_conflict();
    alloc_vld = 2'b10; ap[1] = 6'd9; wb_vld = 4'b0001; wp[0] = 6'd9;
    tick();
    clr(); qp[1] = 6'd9; #1;
    n_chk++; if (query_rdy[1] !== 1'b0) begin n_fail++; $display("FAIL conflict_query9: got %b exp 0", query_rdy[1]); end
    n_chk++; if (busy_cnt !== 7'd1) begin n_fail++; $display("FAIL conflict_busy: got %0d exp 1", busy_cnt); end
    n_chk++; if (wd[0] !== 6'd9) begin n_fail++; $display("FAIL conflict_wb_dest0: got %0d exp 9", wd[0]); end
    wb_vld = 4'b1000; wp[3] = 6'd9;
    tick();
    clr(); #1;
    n_chk++; if (busy_cnt !== 7'd0) begin n_fail++; $display("FAIL conflict_cleanup_busy: got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_null_dup();
    alloc_vld = 2'b11; ap[0] = 6'd0; ap[1] = 6'd12;
    tick();
    clr(); qp[0] = 6'd0; qp[1] = 6'd12; #1;
    n_chk++; if (query_rdy[0] !== 1'b1) begin n_fail++; $display("FAIL null_query0: got %b exp 1", query_rdy[0]); end
    n_chk++; if (query_rdy[1] !== 1'b0) begin n_fail++; $display("FAIL dup_query12_busy: got %b exp 0", query_rdy[1]); end
    n_chk++; if (busy_cnt !== 7'd1) begin n_fail++; $display("FAIL null_busy: got %0d exp 1", busy_cnt); end
    wb_vld = 4'b0011; wp[0] = 6'd12; wp[1] = 6'd12;
    tick();
    clr(); qp[1] = 6'd12; #1;
    n_chk++; if (wd[0] !== 6'd12 || wd[1] !== 6'd12) begin n_fail++; $display("FAIL dup_wb_dest: got ch0=%0d ch1=%0d exp 12 12", wd[0], wd[1]); end
    n_chk++; if (query_rdy[1] !== 1'b1) begin n_fail++; $display("FAIL dup_query12: got %b exp 1", query_rdy[1]); end
    n_chk++; if (busy_cnt !== 7'd0) begin n_fail++; $display("FAIL dup_busy: got %0d exp 0", busy_cnt); end
    wb_vld = 4'b1000; wp[2] = 6'd7; wp[3] = 6'd0;
    tick();
    clr(); #1;
    n_chk++; if (wb_dest !== '0) begin n_fail++; $display("FAIL novalid_null_dest: got %h exp 0", wb_dest); end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 5; c++) begin
      alloc_vld = 2'b11; ap[0] = 6'(1 + 2*c); ap[1] = 6'(2 + 2*c);
      tick();
    end
    clr(); qp[0] = 6'd3; qp[1] = 6'd10; #1;
    n_chk++; if (busy_cnt !== 7'd10) begin n_fail++; $display("FAIL flush_pre_busy: got %0d exp 10", busy_cnt); end
    n_chk++; if (query_rdy[1:0] !== 2'b00) begin n_fail++; $display("FAIL flush_pre_query: got %b exp 00", query_rdy[1:0]); end
    flush = 1'b1; wb_vld = 4'b0010; wp[1] = 6'd3; alloc_vld = 2'b01; ap[0] = 6'd20;
    tick();
    clr(); qp[0] = 6'd3; qp[1] = 6'd20; qp[2] = 6'd1; qp[3] = 6'd10; #1;
    n_chk++; if (busy_cnt !== 7'd0) begin n_fail++; $display("FAIL flush_busy: got %0d exp 0", busy_cnt); end
    n_chk++; if (query_rdy !== 4'hF) begin n_fail++; $display("FAIL flush_query: got %b exp 1111", query_rdy); end
    n_chk++; if (wb_dest !== '0) begin n_fail++; $display("FAIL flush_wb_dest: got %h exp 0", wb_dest); end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 15; c++) begin
      alloc_vld = 2'b11; ap[0] = 6'(30 + 2*c); ap[1] = 6'(31 + 2*c);
      if (c == 14) begin wb_vld = 4'b0001; wp[0] = 6'd2; end
      tick();
    end
    clr(); qp[0] = 6'd30; qp[1] = 6'd45; qp[2] = 6'd59; qp[3] = 6'd2; #1;
    n_chk++; if (busy_cnt !== 7'd30) begin n_fail++; $display("FAIL areset_pre_busy: got %0d exp 30", busy_cnt); end
    n_chk++; if (wd[0] !== 6'd2) begin n_fail++; $display("FAIL areset_pre_dest: got %0d exp 2", wd[0]); end
    n_chk++; if (query_rdy !== 4'b1000) begin n_fail++; $display("FAIL areset_pre_query: got %b exp 1000", query_rdy); end
    rst = 1'b1; #1;
    n_chk++; if (busy_cnt !== 7'd0) begin n_fail++; $display("FAIL areset_busy: got %0d exp 0", busy_cnt); end
    n_chk++; if (wb_dest !== '0) begin n_fail++; $display("FAIL areset_dest: got %h exp 0", wb_dest); end
    n_chk++; if (query_rdy !== 4'hF) begin n_fail++; $display("FAIL areset_query: got %b exp 1111", query_rdy); end
    tick();
    rst = 1'b0;
    tick();
    n_chk++; if (busy_cnt !== 7'd0) begin n_fail++; $display("FAIL areset_release_busy: got %0d exp 0", busy_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    clr();
    test_reset();
    test_alloc_wake();
    test_conflict();
    test_null_dup();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
